// File: rtl/addr_sequencer.sv
// addr_sequencer: start/stride/count address walker on a valid/ready stream with last, busy and done.
// Define ADDR_SEQ_WRAP_EN to add cfg_wrap_limit and restart from the start address past the limit.
module addr_sequencer #(
  parameter int ADDR_W   = 32,
  parameter int CNT_W    = 16,
  parameter int STRIDE_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   cfg_start_addr,
  input  logic [STRIDE_W-1:0] cfg_stride,
  input  logic [CNT_W-1:0]    cfg_count,
`ifdef ADDR_SEQ_WRAP_EN
  input  logic [ADDR_W-1:0]   cfg_wrap_limit,
`endif
  input  logic                cfg_valid,
  output logic                cfg_ready,
  output logic [ADDR_W-1:0]   addr_out,
  output logic                addr_valid,
  input  logic                addr_ready,
  output logic                addr_last,
  output logic                busy,
  output logic                done
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  logic [0:0]          state;
  logic [CNT_W-1:0]    remaining;
  logic [STRIDE_W-1:0] stride_q;
  logic [ADDR_W:0]     sum;
  logic [ADDR_W-1:0]   next_addr;
  logic                cfg_hs, addr_hs, final_hs;
  assign cfg_hs    = cfg_valid && cfg_ready;
  assign addr_hs   = addr_valid && addr_ready;
  assign final_hs  = addr_hs && remaining == CNT_W'(1);
  assign sum       = {1'b0, addr_out} + (ADDR_W+1)'(stride_q);
  assign addr_last = addr_valid && remaining == CNT_W'(1);
  assign busy      = state == RUN;
`ifdef ADDR_SEQ_WRAP_EN
  logic [ADDR_W-1:0] start_q, limit_q;
  // the compare is one bit wider so a carry out of the adder also counts as passing the limit
  assign next_addr = sum > {1'b0, limit_q} ? start_q : sum[ADDR_W-1:0];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      start_q <= '0;
      limit_q <= '0;
    end else if (cfg_hs) begin
      start_q <= cfg_start_addr;
      limit_q <= cfg_wrap_limit;
    end
`else
  assign next_addr = sum[ADDR_W-1:0];
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      addr_out   <= '0;
      addr_valid <= 1'b0;
      remaining  <= '0;
      stride_q   <= '0;
      done       <= 1'b0;
      cfg_ready  <= 1'b0;
    end else begin
      done <= (cfg_hs && cfg_count == '0) || final_hs;
      if (cfg_hs && cfg_count != '0) begin
        state      <= RUN;
        addr_out   <= cfg_start_addr;
        addr_valid <= 1'b1;
        remaining  <= cfg_count;
        stride_q   <= cfg_stride;
        cfg_ready  <= 1'b0;
      end else if (final_hs) begin
        state      <= IDLE;
        addr_valid <= 1'b0;
        remaining  <= '0;
        cfg_ready  <= 1'b1;
      end else if (addr_hs) begin
        addr_out  <= next_addr;
        remaining <= remaining - CNT_W'(1);
      end else if (state == IDLE) begin
        cfg_ready <= 1'b1;
      end
    end
endmodule

// File: tb/tb_addr_sequencer.sv
// tb_addr_sequencer: scoreboard bench, reference sequences computed from start/stride/count arithmetic.
module tb_addr_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cfg_start_addr = '0;
  logic [7:0]  cfg_stride = '0;
  logic [15:0] cfg_count = '0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [31:0] addr_out;
  logic        addr_valid;
  logic        addr_ready = 1'b0;
  logic        addr_last;
  logic        busy;
  logic        done;
`ifdef ADDR_SEQ_WRAP_EN
  logic [31:0] cfg_wrap_limit = '0;
  logic [31:0] wrap_lim = 32'hFFFF_FFFF;
`endif
  int tests = 0, errors = 0;
  int hs_cnt = 0, hs_base = 0, done_seen = 0, exp_done = 0, ready_mode = 0, cur_n = 0;
  logic [31:0] exp_addr[$];
  bit          exp_last[$];
  logic        stall = 1'b0;
  logic [31:0] held = '0;

  addr_sequencer dut (
    .clk(clk), .rst(rst),
    .cfg_start_addr(cfg_start_addr), .cfg_stride(cfg_stride), .cfg_count(cfg_count),
`ifdef ADDR_SEQ_WRAP_EN
    .cfg_wrap_limit(cfg_wrap_limit),
`endif
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .addr_out(addr_out), .addr_valid(addr_valid), .addr_ready(addr_ready),
    .addr_last(addr_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic req);
    tests++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", nm, act, req);
    end
  endtask

  // Reference: the i-th address is start + i*stride mod 2^32, or the ring walk when wrapping is built in.
  task automatic push_exp(input logic [31:0] s, input logic [7:0] st, input int n);
    logic [32:0] nx;
    logic [31:0] a = s;
    for (int i = 0; i < n; i++) begin
`ifdef ADDR_SEQ_WRAP_EN
      exp_addr.push_back(a);
      nx = {1'b0, a} + 33'(st);
      a = nx > {1'b0, wrap_lim} ? s : nx[31:0];
`else
      nx = '0;
      a = s + 32'(i) * 32'(st);
      exp_addr.push_back(a);
`endif
      exp_last.push_back(i == n - 1);
    end
  endtask

  task automatic issue(input logic [31:0] s, input logic [7:0] st, input logic [15:0] n, input int mode);
    ready_mode = mode;
    cfg_start_addr = s;
    cfg_stride = st;
    cfg_count = n;
`ifdef ADDR_SEQ_WRAP_EN
    cfg_wrap_limit = wrap_lim;
`endif
    cfg_valid = 1'b1;
    for (int k = 0; k < 50 && !cfg_ready; k++) @(negedge clk);
    chk1("cfg_ready_wait", cfg_ready, 1'b1);
    push_exp(s, st, int'(n));
    exp_done++;
    hs_base = hs_cnt;
    cur_n = int'(n);
    @(posedge clk);
    #1 cfg_valid = 1'b0;
    @(negedge clk);
    chk1("first_valid", addr_valid, n != 0);
    chk1("busy_start", busy, n != 0);
    chk1("cfg_ready_after_cfg", cfg_ready, n == 0);
    chk1("done_after_cfg", done, n == 0);
    if (n != 0) chk("first_addr", addr_out, s);
  endtask

  task automatic finish_seq();
    for (int k = 0; k < 20 * cur_n + 20 && !done; k++) @(negedge clk);
    chk1("done_seen", done, 1'b1);
    chk1("valid_at_done", addr_valid, 1'b0);
    chk1("busy_at_done", busy, 1'b0);
    chk1("cfg_ready_at_done", cfg_ready, 1'b1);
    chk("handshakes", 32'(hs_cnt - hs_base), 32'(cur_n));
    chk("queue_left", 32'(exp_addr.size()), 32'd0);
    exp_addr.delete();
    exp_last.delete();
  endtask

  initial begin
    int pat = 0;
    forever begin
      @(posedge clk);
      #1;
      addr_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? pat == 0 : $urandom_range(3) != 0;
      pat = (pat + 1) % 3;
    end
  end

  // Monitor: compares every presented address against the scoreboard head, pops on handshake.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      stall = 1'b0;
      continue;
    end
    if (stall) begin
      chk1("stall_valid_held", addr_valid, 1'b1);
      chk("stall_addr_held", addr_out, held);
    end
    if (addr_valid) begin
      if (exp_addr.size() == 0) begin
        tests++;
        errors++;
        $display("FAIL unexpected_addr: got %h, expected no address", addr_out);
      end else begin
        chk("addr", addr_out, exp_addr[0]);
        chk1("addr_last", addr_last, exp_last[0]);
        if (addr_ready) begin
          void'(exp_addr.pop_front());
          void'(exp_last.pop_front());
          hs_cnt++;
        end
      end
    end else if (addr_last) begin
      chk1("last_without_valid", addr_last, 1'b0);
    end
    if (done) done_seen++;
    stall = addr_valid && !addr_ready;
    held = addr_out;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] s;
    logic [7:0]  st;
    logic [15:0] n;
    #12;
    chk("rst_addr_out", addr_out, 32'd0);
    chk1("rst_valid", addr_valid, 1'b0);
    chk1("rst_last", addr_last, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1 chk1("cfg_ready_after_rst", cfg_ready, 1'b1);
    @(negedge clk);
    issue(32'h1000, 8'd4, 16'd4, 0);
    finish_seq();
    issue(32'h1000, 8'd4, 16'd4, 1);
    finish_seq();
    issue(32'h0, 8'd4, 16'd0, 0);
    finish_seq();
    issue(32'h20, 8'd0, 16'd3, 2);
    finish_seq();
    issue(32'hFFFF_FFFE, 8'd1, 16'd4, 0);
    finish_seq();
    issue(32'h5000, 8'd3, 16'd8, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk1("midrst_valid", addr_valid, 1'b0);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_done", done, 1'b0);
    chk1("midrst_last", addr_last, 1'b0);
    chk("midrst_addr", addr_out, 32'd0);
    chk("midrst_remaining", 32'(exp_addr.size()), 32'd6);
    exp_addr.delete();
    exp_last.delete();
    exp_done--;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    chk1("postrst_cfg_ready", cfg_ready, 1'b1);
    chk1("postrst_done", done, 1'b0);
    chk1("postrst_valid", addr_valid, 1'b0);
    @(negedge clk);
    issue(32'h7000, 8'd8, 16'd3, 1);
    finish_seq();
`ifdef ADDR_SEQ_WRAP_EN
    wrap_lim = 32'h120;
    issue(32'h100, 8'h10, 16'd5, 0);
    finish_seq();
`endif
    for (int t = 0; t < 30; t++) begin
      s = $urandom_range(1) != 0 ? $urandom : 32'hFFFF_FF00 + 32'($urandom_range(255));
      st = $urandom_range(3) == 0 ? 8'd0 : 8'($urandom_range(255));
      n = 16'($urandom_range(12));
`ifdef ADDR_SEQ_WRAP_EN
      wrap_lim = $urandom_range(3) == 0 ? s - 32'($urandom_range(50)) : s + 32'($urandom_range(300));
`endif
      issue(s, st, n, int'($urandom_range(2)));
      finish_seq();
    end
    @(negedge clk);
    chk("done_pulses", 32'(done_seen), 32'(exp_done));
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
